// File: rtl/commit_pkg.sv
// ============================================================================
// Module      : commit_pkg
// Description : Shared definitions for the commit-stream checker: field
//               widths, flag bit positions, error codes, FSM state encoding,
//               the packed commit-record type and the record comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_pkg;

    // Field widths of one retirement record
    localparam int c_PC_W    = 16;
    localparam int c_FLAGS_W = 4;
    localparam int c_WREG_W  = 3;
    localparam int c_DATA_W  = 16;
    localparam int c_ADDR_W  = 16;

    // Bit positions inside flags = {halt, memread, memwrite, regwrite}
    localparam int c_FLAG_REGWRITE = 0;
    localparam int c_FLAG_MEMWRITE = 1;
    localparam int c_FLAG_MEMREAD  = 2;
    localparam int c_FLAG_HALT     = 3;

    // Failure causes reported on err_code
    localparam logic [2:0] c_ERR_NONE     = 3'd0;
    localparam logic [2:0] c_ERR_PC       = 3'd1;
    localparam logic [2:0] c_ERR_FLAGS    = 3'd2;
    localparam logic [2:0] c_ERR_REG      = 3'd3;
    localparam logic [2:0] c_ERR_MEM      = 3'd4;
    localparam logic [2:0] c_ERR_OVERFLOW = 3'd5;
    localparam logic [2:0] c_ERR_POSTHALT = 3'd6;

    // Checker FSM encoding
    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DONE  = 2'd1;
    localparam logic [1:0] c_ST_ERROR = 2'd2;

    typedef struct packed {
        logic [c_PC_W-1:0]    pc;
        logic [c_FLAGS_W-1:0] flags;
        logic [c_WREG_W-1:0]  wreg;
        logic [c_DATA_W-1:0]  wdata;
        logic [c_ADDR_W-1:0]  addr;
        logic [c_DATA_W-1:0]  mdata;
    } commit_rec_t;

    localparam int c_REC_W = $bits(commit_rec_t);

    // Compare a retired record against the expected one. Checks run in
    // priority order; fields not selected by the flags are ignored. Once the
    // flag check has passed both sides carry identical flags, so the expected
    // flags alone decide which payload fields matter.
    function automatic logic [2:0] compareRecords(commit_rec_t act, commit_rec_t exp);
        logic [2:0] code;
        code = c_ERR_NONE;
        if (act.pc != exp.pc) begin
            code = c_ERR_PC;
        end else if (act.flags != exp.flags) begin
            code = c_ERR_FLAGS;
        end else if (exp.flags[c_FLAG_REGWRITE] &&
                     ((act.wreg != exp.wreg) || (act.wdata != exp.wdata))) begin
            code = c_ERR_REG;
        end else if ((exp.flags[c_FLAG_MEMWRITE] &&
                      ((act.addr != exp.addr) || (act.mdata != exp.mdata))) ||
                     (exp.flags[c_FLAG_MEMREAD] && (act.addr != exp.addr))) begin
            code = c_ERR_MEM;
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/commit_fifo.sv
// ============================================================================
// Module      : commit_fifo
// Description : Synchronous FIFO with full/empty flags. A push while full is
//               accepted only when a pop happens in the same cycle, so the
//               occupancy stays at DEPTH. The head entry is presented
//               combinationally on popData.
// Ports       : clk, rst (sync, active-low), push/pushData, pop/popData,
//               full, empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;

    logic w_doPop;
    logic w_doPush;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_CNT_FULL);
    assign w_doPop  = pop & ~empty;
    // Pop frees the head slot first, making room for a push while full
    assign w_doPush = push & (~full | w_doPop);
    assign popData  = r_mem[r_rdPtr];

    // Storage carries no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/commit_checker.sv
// ============================================================================
// Module      : commit_checker
// Description : Compares the processor's live retirement stream against an
//               expected trace delivered over a valid/ready handshake.
//               Retired commits are buffered; each cycle with a buffered
//               commit and a valid expected record performs one compare.
//               The first failure is latched with its cause and index.
// Ports       : clk, rst (sync, active-low)
//               cm_*      - retirement tap (valid, pc, flags, wreg, wdata,
//                           addr, mdata)
//               exp_*     - expected record input, exp_ready = consumed
//               done      - halt record matched
//               error     - sticky failure, err_code/err_inum describe it
//               inum      - records matched so far
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_checker
    import commit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int INUM_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cm_valid,
    input  logic [c_PC_W-1:0]    cm_pc,
    input  logic [c_FLAGS_W-1:0] cm_flags,
    input  logic [c_WREG_W-1:0]  cm_wreg,
    input  logic [c_DATA_W-1:0]  cm_wdata,
    input  logic [c_ADDR_W-1:0]  cm_addr,
    input  logic [c_DATA_W-1:0]  cm_mdata,
    input  logic                 exp_valid,
    output logic                 exp_ready,
    input  logic [c_PC_W-1:0]    exp_pc,
    input  logic [c_FLAGS_W-1:0] exp_flags,
    input  logic [c_WREG_W-1:0]  exp_wreg,
    input  logic [c_DATA_W-1:0]  exp_wdata,
    input  logic [c_ADDR_W-1:0]  exp_addr,
    input  logic [c_DATA_W-1:0]  exp_mdata,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           err_code,
    output logic [INUM_W-1:0]    inum,
    output logic [INUM_W-1:0]    err_inum
);

    localparam logic [INUM_W-1:0] c_INUM_ONE = {{(INUM_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic              r_done;
    logic              r_error;
    logic [2:0]        r_errCode;
    logic [INUM_W-1:0] r_inum;
    logic [INUM_W-1:0] r_errInum;

    commit_rec_t w_cmRec;
    commit_rec_t w_expRec;
    commit_rec_t w_head;
    logic [c_REC_W-1:0] w_headBits;
    logic        w_full;
    logic        w_empty;
    logic        w_run;
    logic        w_pushReq;
    logic        w_overflow;
    logic [2:0]  w_cmpCode;

    assign w_cmRec  = '{pc: cm_pc, flags: cm_flags, wreg: cm_wreg,
                        wdata: cm_wdata, addr: cm_addr, mdata: cm_mdata};
    assign w_expRec = '{pc: exp_pc, flags: exp_flags, wreg: exp_wreg,
                        wdata: exp_wdata, addr: exp_addr, mdata: exp_mdata};
    assign w_head   = commit_rec_t'(w_headBits);

    assign w_run     = (r_state == c_ST_RUN);
    assign w_pushReq = w_run & cm_valid;
    assign exp_ready = w_run & ~w_empty & exp_valid;
    assign w_cmpCode = compareRecords(w_head, w_expRec);
    // A pop in the same cycle makes room, so only an unpaired push overflows
    assign w_overflow = w_pushReq & w_full & ~exp_ready;

    commit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_pushReq),
        .pushData (w_cmRec),
        .pop      (exp_ready),
        .popData  (w_headBits),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_ST_RUN;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_errCode <= c_ERR_NONE;
            r_inum    <= '0;
            r_errInum <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    // Compare outcome takes precedence over the overflow check
                    if (exp_ready && (w_cmpCode != c_ERR_NONE)) begin
                        r_state   <= c_ST_ERROR;
                        r_error   <= 1'b1;
                        r_errCode <= w_cmpCode;
                        r_errInum <= r_inum;
                    end else begin
                        if (exp_ready) begin
                            r_inum <= r_inum + c_INUM_ONE;
                            if (w_head.flags[c_FLAG_HALT]) begin
                                r_state <= c_ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                        // Overflow implies no pop this cycle, so it never
                        // coincides with the halt transition above
                        if (w_overflow) begin
                            r_state   <= c_ST_ERROR;
                            r_error   <= 1'b1;
                            r_errCode <= c_ERR_OVERFLOW;
                            r_errInum <= r_inum;
                        end
                    end
                end
                c_ST_DONE: begin
                    // Any retirement after the halt is a failure; done stays set
                    if (cm_valid) begin
                        r_state   <= c_ST_ERROR;
                        r_error   <= 1'b1;
                        r_errCode <= c_ERR_POSTHALT;
                        r_errInum <= r_inum;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_errCode;
    assign inum     = r_inum;
    assign err_inum = r_errInum;

endmodule

`default_nettype wire

// File: doc/commit_checker.md
# commit_checker

Synthesizable commit-stream checker that consumes an expected instruction trace record-by-record and compares it against the processor's live retirement stream. Where the simulation bench writes the trace, this block reads it back and checks it. It sits beside `proc` in `proc_hier`, taps the same retirement signals the trace uses, and raises a sticky error with the failing instruction number. Expected records come from a ROM/FIFO loader via a valid/ready handshake.

## Interface

Parameters:
- `DEPTH`, 4: commit buffer entries (power of two, ≥2)
- `INUM_W`, 32: instruction counter width

Ports:
- `clk` in 1: clock, all state updates on posedge
- `rst` in 1: synchronous, active-low reset; one clock `clk`
- `cm_valid` in 1: one instruction retired this cycle
- `cm_pc` in 16: retired PC
- `cm_flags` in 4: {halt, memread, memwrite, regwrite}
- `cm_wreg` in 3: register written
- `cm_wdata` in 16: register write data
- `cm_addr` in 16: memory address
- `cm_mdata` in 16: memory write data
- `exp_valid` in 1: expected record available
- `exp_ready` out 1: record consumed this cycle
- `exp_pc`, `exp_flags`, `exp_wreg`, `exp_wdata`, `exp_addr`, `exp_mdata`: in, same widths as `cm_*`
- `done` out 1: halt record matched, run passed
- `error` out 1: sticky failure
- `err_code` out 3: failure cause
- `inum` out INUM_W: records matched so far
- `err_inum` out INUM_W: index of the failing record

## Operation

- States: RUN (after reset), DONE, ERROR. DONE and ERROR hold until reset.
- Commit buffer: FIFO of `DEPTH` commit records. Push on `cm_valid` in RUN.
- `exp_ready` = RUN & buffer non-empty & `exp_valid`. A compare fires on that cycle: pop the buffer head and consume the expected record.
- Compare rules, in priority order:
  - PC differs → code 1
  - flags differ → code 2
  - regwrite set and (`wreg` or `wdata` differ) → code 3
  - memwrite set and (`addr` or `mdata` differ), or memread set and `addr` differs → code 4
  - Fields not selected by the flags are don't-care.
- Match: `inum` += 1. If halt is set → DONE.
- Mismatch → ERROR, with `err_inum` = current `inum` (the value before any increment).
- Overflow: push while full with no simultaneous pop → code 5, ERROR. Push and pop in the same cycle while full is legal, and occupancy stays at `DEPTH`.
- `cm_valid` in DONE → code 6 (commit after halt), ERROR.
- In ERROR, `cm_valid` and `exp_valid` are ignored. `exp_ready` = 0 in DONE and ERROR.
- Error codes: 0 none, 1 pc, 2 flags, 3 reg, 4 mem, 5 overflow, 6 post-halt. Only the first error is recorded.
- `inum` wraps modulo 2^INUM_W without flagging.
- Same-cycle precedence: a compare mismatch beats overflow; the compare outcome of cycle t is evaluated before the push check.

## Timing

- Reset values: `exp_ready` 0, `done` 0, `error` 0, `err_code` 0, `inum` 0, `err_inum` 0. Buffer is empty, state is RUN.
- Reset applies mid-run in a single cycle and discards buffered commits.
- A commit pushed at edge t can be compared no earlier than cycle t+1 (minimum 1-cycle latency).
- `exp_ready` is combinational from registered state and `exp_valid`.
- A compare in cycle t updates `inum`, `done`, `error`, `err_code` and `err_inum` at edge t+1.
- Throughput: one compare per cycle.
- `exp_*` fields must be stable while `exp_valid`=1 and `exp_ready`=0.

## Structure

- Package `commit_pkg`: field widths, flag bit positions, `err_code` constants, state encoding, and the packed commit-record typedef.
- Sub-module `commit_fifo`: parameterized synchronous FIFO with full/empty, push/pop, and same-cycle push+pop when full.
- `commit_checker` holds the FSM, the comparator and the counters.

## Test plan

- Three matching commits, PC 0x0000/0x0002/0x0004 with regwrite r1 = 0x0005, then a halt record at 0x0006 → `done`=1 one cycle after the halt compare, `inum`=4, `error`=0.
- Second record expects `wdata` 0x0005 but commit has 0x0006 → `error`=1, `err_code`=3, `err_inum`=1, `exp_ready` stays 0 afterward.
- `exp_valid` held 0 while 5 commits arrive with `DEPTH`=4 → fifth push gives `err_code`=5. Repeat with `exp_valid` asserted on the fifth cycle → no error, occupancy 4.
- Store commit with `addr` 0x0010 and `mdata` 0xBEEF where the record has `mdata` 0xBEEE → `err_code`=4. Load commit with a differing `wdata` but regwrite=0 → match.
- Halt matched, then `cm_valid` pulses → `err_code`=6, `done` stays 1, `error`=1.
- Reset asserted with 2 commits buffered and `inum`=7 → all outputs return to reset values on the next edge, and a fresh matching sequence passes.
